// File: rtl/gate_capture_controller.sv
// Measurement sequencer for the frequency counter. It clears, gates and freezes the
// clk_x BCD counter, snapshots the result, and hands it to the streamer with a strobe.
module gate_capture_controller #(
  parameter int DIGITS_NUM    = 6,
  parameter int GATE_CYCLES   = 1000000,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter bit BLANK_ZEROS   = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  input  logic                    run_in,
  input  logic [4*DIGITS_NUM-1:0] cnt_digits_in,
  input  logic                    cnt_ovf_in,
  output logic                    cnt_reset_out,
  output logic                    cnt_enable_out,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    overflow_out,
  output logic                    refresh_stb_out,
  input  logic                    streamer_ready_in,
  output logic                    gate_active_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_GATE    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  localparam int MAX_LOAD = (GATE_CYCLES > CLEAR_CYCLES) ?
                            ((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) :
                            ((CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES);
  localparam int CW = $clog2(MAX_LOAD + 1);
  localparam int DW = 4 * DIGITS_NUM;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_ovf_meta;
  logic          r_ovf_sync;
  logic          r_pending;
  logic          w_pending_eff;
  logic          r_cnt_reset;
  logic          r_cnt_enable;
  logic          r_gate_active;
  logic          r_refresh_stb;
  logic          r_overflow;
  logic [DW-1:0] r_digits;
  logic [DW-1:0] w_blanked;

  // One down-counter is shared by every timed state; it is reloaded on each transition.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (run_in) begin
          w_state_next = S_CLEAR;
          w_cnt_next   = CW'(CLEAR_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        if (r_cnt == '0) begin
          w_state_next = S_GATE;
          w_cnt_next   = CW'(GATE_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_GATE: begin
        if (r_cnt == '0) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = CW'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_next = S_CAPTURE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_CAPTURE: begin
        if (run_in) begin
          w_state_next = S_CLEAR;
          w_cnt_next   = CW'(CLEAR_CYCLES - 1);
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Leading-zero blanking; digit 0 always stays visible.
  always_comb begin : blank_proc
    logic w_lead;
    w_blanked = cnt_digits_in;
    w_lead    = BLANK_ZEROS;
    for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
      if (w_lead && (cnt_digits_in[4*i +: 4] == 4'd0)) begin
        w_blanked[4*i +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  // A capture in progress counts as pending so the strobe can leave with the new snapshot.
  assign w_pending_eff = r_pending || (r_state == S_CAPTURE);

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ovf_meta    <= 1'b0;
      r_ovf_sync    <= 1'b0;
      r_pending     <= 1'b0;
      r_cnt_reset   <= 1'b1;
      r_cnt_enable  <= 1'b0;
      r_gate_active <= 1'b0;
      r_refresh_stb <= 1'b0;
      r_overflow    <= 1'b0;
      r_digits      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_ovf_meta    <= cnt_ovf_in;
      r_ovf_sync    <= r_ovf_meta;
      r_cnt_reset   <= (w_state_next == S_IDLE) || (w_state_next == S_CLEAR);
      r_cnt_enable  <= (w_state_next == S_GATE);
      r_gate_active <= (w_state_next == S_GATE);
      if (r_state == S_CAPTURE) begin
        r_digits   <= w_blanked;
        r_overflow <= r_ovf_sync;
      end
      if (w_pending_eff && streamer_ready_in) begin
        r_refresh_stb <= 1'b1;
        r_pending     <= 1'b0;
      end else begin
        r_refresh_stb <= 1'b0;
        r_pending     <= w_pending_eff;
      end
    end
  end

  assign cnt_reset_out   = r_cnt_reset;
  assign cnt_enable_out  = r_cnt_enable;
  assign gate_active_out = r_gate_active;
  assign refresh_stb_out = r_refresh_stb;
  assign overflow_out    = r_overflow;
  assign digits_out      = r_digits;

endmodule

// File: tb/tb_gate_capture_controller.sv
// Bench for gate_capture_controller: directed frames with a scoreboard of expected
// snapshots popped by a strobe monitor, plus timing checks on gate and frame length.
module tb_gate_capture_controller;

  localparam int DN = 6;
  localparam int GC = 20;
  localparam int CC = 2;
  localparam int SC = 3;

  logic          clk_in = 1'b0;
  logic          rstn_in = 1'b0;
  logic          run_in = 1'b0;
  logic [23:0]   cnt_digits_in = 24'h0;
  logic          cnt_ovf_in;
  logic          streamer_ready_in = 1'b0;
  logic          cnt_reset_out;
  logic          cnt_enable_out;
  logic [23:0]   digits_out;
  logic          overflow_out;
  logic          refresh_stb_out;
  logic          gate_active_out;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int strobes = 0;
  int gate_run = 0;
  logic [24:0] exp_q[$];

  logic ovf_model = 1'b0;
  logic ovf_pulse = 1'b0;
  assign cnt_ovf_in = ovf_model;

  gate_capture_controller #(
    .DIGITS_NUM(DN), .GATE_CYCLES(GC), .CLEAR_CYCLES(CC),
    .SETTLE_CYCLES(SC), .BLANK_ZEROS(1'b1)
  ) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .run_in(run_in),
    .cnt_digits_in(cnt_digits_in), .cnt_ovf_in(cnt_ovf_in),
    .cnt_reset_out(cnt_reset_out), .cnt_enable_out(cnt_enable_out),
    .digits_out(digits_out), .overflow_out(overflow_out),
    .refresh_stb_out(refresh_stb_out), .streamer_ready_in(streamer_ready_in),
    .gate_active_out(gate_active_out)
  );

  always #5 clk_in = ~clk_in;

  // Counter-domain model: sticky overflow, cleared while the counter is held in reset.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (cnt_reset_out) ovf_model <= 1'b0;
    else if (ovf_pulse) ovf_model <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_en(input logic lvl, input string name);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((cnt_enable_out !== lvl) && (n < 200));
    if (cnt_enable_out !== lvl) check(name, 32'(cnt_enable_out), 32'(lvl));
  endtask

  always @(negedge clk_in) begin
    if (rstn_in && refresh_stb_out) begin
      strobes++;
      $display("strobe cyc=%0d digits_out=%h overflow_out=%b", cyc, digits_out, overflow_out);
      if (exp_q.size() == 0) begin
        check("strobe_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("strobe_digits", 32'(digits_out), 32'(e[23:0]));
        check("strobe_ovf", 32'(overflow_out), 32'(e[24]));
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rstn_in) gate_run = 0;
    else if (cnt_enable_out) gate_run++;
    else if (gate_run != 0) begin
      check("gate_len", 32'(gate_run), 32'(GC));
      gate_run = 0;
    end
  end

  initial begin
    int t0, t1, k, r, en_cnt, strobes_before;

    repeat (3) @(negedge clk_in);
    check("rst_cnt_reset", 32'(cnt_reset_out), 32'd1);
    check("rst_cnt_enable", 32'(cnt_enable_out), 32'd0);
    check("rst_digits", 32'(digits_out), 32'd0);
    check("rst_overflow", 32'(overflow_out), 32'd0);
    check("rst_strobe", 32'(refresh_stb_out), 32'd0);
    check("rst_gate_active", 32'(gate_active_out), 32'd0);

    // Frame 1: 000123 with the streamer ready.
    cnt_digits_in = 24'h000123;
    streamer_ready_in = 1'b1;
    run_in = 1'b1;
    exp_q.push_back({1'b0, 24'hFFF123});
    @(negedge clk_in);
    rstn_in = 1'b1;
    wait_en(1'b1, "gate1_start");
    t0 = cyc;
    check("gate_active_in_gate", 32'(gate_active_out), 32'd1);
    wait_en(1'b0, "gate1_end");
    k = 0;
    while (!refresh_stb_out && k < 10) begin
      @(negedge clk_in);
      k++;
    end
    check("capture_to_strobe", 32'(k), 32'd4);
    check("digits_at_strobe", 32'(digits_out), 32'hFFF123);

    // Frames 2 and 3 captured with the streamer busy; only the newest is sent.
    streamer_ready_in = 1'b0;
    cnt_digits_in = 24'h000050;
    r = 0;
    k = 0;
    while (!cnt_enable_out && k < 20) begin
      if (cnt_reset_out) r++;
      @(negedge clk_in);
      k++;
    end
    t1 = cyc;
    check("clear_len", 32'(r), 32'(CC));
    check("frame_period", 32'(t1 - t0), 32'(CC + GC + SC + 1));
    exp_q.push_back({1'b0, 24'hFFFF51});
    wait_en(1'b0, "gate2_end");
    wait_en(1'b1, "gate3_start");
    check("snapshot_unsent", 32'(digits_out), 32'hFFFF50);
    cnt_digits_in = 24'h000051;
    wait_en(1'b0, "gate3_end");
    wait_en(1'b1, "gate4_start");
    check("snapshot_overwritten", 32'(digits_out), 32'hFFFF51);
    streamer_ready_in = 1'b1;
    @(negedge clk_in);
    check("late_strobe", 32'(refresh_stb_out), 32'd1);

    // Frame 4: overflow pulse during the gate.
    exp_q.push_back({1'b1, 24'hFFFF51});
    ovf_pulse = 1'b1;
    @(negedge clk_in);
    ovf_pulse = 1'b0;
    wait_en(1'b0, "gate4_end");
    wait_en(1'b1, "gate5_start");
    check("ovf_captured", 32'(overflow_out), 32'd1);
    cnt_digits_in = 24'h987654;
    exp_q.push_back({1'b0, 24'h987654});
    wait_en(1'b0, "gate5_end");
    wait_en(1'b1, "gate6_start");
    check("ovf_cleared", 32'(overflow_out), 32'd0);
    check("digits_no_blank", 32'(digits_out), 32'h987654);
    cnt_digits_in = 24'h000000;
    exp_q.push_back({1'b0, 24'hFFFFF0});

    // Frame 7: run dropped mid-gate; frame completes then idles.
    wait_en(1'b0, "gate6_end");
    wait_en(1'b1, "gate7_start");
    cnt_digits_in = 24'h100000;
    exp_q.push_back({1'b0, 24'h100000});
    repeat (5) @(negedge clk_in);
    run_in = 1'b0;
    k = 0;
    while (!refresh_stb_out && k < 60) begin
      @(negedge clk_in);
      k++;
    end
    check("run_drop_strobe", 32'(refresh_stb_out), 32'd1);
    check("run_drop_digits", 32'(digits_out), 32'h100000);
    en_cnt = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (cnt_enable_out) en_cnt++;
    end
    check("idle_no_gate", 32'(en_cnt), 32'd0);
    check("idle_cnt_reset", 32'(cnt_reset_out), 32'd1);

    // Reset asserted mid-gate aborts everything immediately.
    run_in = 1'b1;
    cnt_digits_in = 24'h000777;
    wait_en(1'b1, "gate8_start");
    repeat (5) @(negedge clk_in);
    strobes_before = strobes;
    rstn_in = 1'b0;
    #1;
    check("abort_cnt_enable", 32'(cnt_enable_out), 32'd0);
    check("abort_cnt_reset", 32'(cnt_reset_out), 32'd1);
    check("abort_digits", 32'(digits_out), 32'd0);
    check("abort_overflow", 32'(overflow_out), 32'd0);
    check("abort_gate_active", 32'(gate_active_out), 32'd0);
    @(negedge clk_in);
    run_in = 1'b0;
    @(negedge clk_in);
    rstn_in = 1'b1;
    repeat (40) @(negedge clk_in);
    check("abort_no_strobe", 32'(strobes), 32'(strobes_before));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
